// File: rtl/axis_tx_pkg.sv
// Shared constants, arbiter state encoding and width helper for the AXIS TX arbiter.
package axis_tx_pkg;

    localparam int unsigned C_AXIS_DATA_WIDTH = 32'd1024;
    localparam int unsigned C_NUM_SRC         = 32'd4;
    localparam int unsigned C_PKT_CNT_WIDTH   = 32'd32;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr, wrapping, with ptr itself checked last.
module axis_rr_pick
    import axis_tx_pkg::*;
#(
    parameter  int unsigned G_NUM_SRC = C_NUM_SRC,
    localparam int unsigned IDX_W     = clog2(G_NUM_SRC)
) (
    input  logic [G_NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 found
);

    int unsigned cand_s;

    // Scan ptr+1 .. ptr+G_NUM_SRC so the previous owner only wins when it is alone.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand_s = 32'd0;
        for (int unsigned k = 32'd1; k <= G_NUM_SRC; k++) begin
            cand_s = (32'(ptr) + k) % G_NUM_SRC;
            if (!found && req[cand_s[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand_s[IDX_W-1:0];
            end else begin
                found  = found;
            end
        end
    end

endmodule

// File: rtl/axis_tx_arb.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream TX port among several sources.
module axis_tx_arb
    import axis_tx_pkg::*;
#(
    parameter  int unsigned G_AXIS_DATA_WIDTH = C_AXIS_DATA_WIDTH,
    parameter  int unsigned G_NUM_SRC         = C_NUM_SRC,
    localparam int unsigned KEEP_W            = G_AXIS_DATA_WIDTH / 32'd8,
    localparam int unsigned IDX_W             = clog2(G_NUM_SRC)
) (
    input  logic                                   axis_streaming_data_clk,
    input  logic                                   axis_streaming_arst,
    input  logic [G_NUM_SRC-1:0]                   src_enable,
    input  logic [G_NUM_SRC*G_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [G_NUM_SRC*KEEP_W-1:0]            s_axis_tkeep,
    input  logic [G_NUM_SRC-1:0]                   s_axis_tvalid,
    input  logic [G_NUM_SRC-1:0]                   s_axis_tuser,
    input  logic [G_NUM_SRC-1:0]                   s_axis_tlast,
    output logic [G_NUM_SRC-1:0]                   s_axis_tready,
    output logic [G_AXIS_DATA_WIDTH-1:0]           axis_streaming_data_tx_tdata,
    output logic [KEEP_W-1:0]                      axis_streaming_data_tx_tkeep,
    output logic                                   axis_streaming_data_tx_tvalid,
    output logic                                   axis_streaming_data_tx_tuser,
    output logic                                   axis_streaming_data_tx_tlast,
    input  logic                                   axis_streaming_data_tx_tready,
    output logic [IDX_W-1:0]                       arb_grant_idx,
    output logic                                   arb_busy,
    output logic [C_PKT_CNT_WIDTH-1:0]             arb_pkt_cnt
);

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                       busy_q, busy_d;

    logic [G_NUM_SRC-1:0]       req_s;
    logic [IDX_W-1:0]           pick_ptr_s;
    logic [IDX_W-1:0]           pick_winner_s;
    logic                       pick_found_s;
    logic                       last_beat_s;

    assign req_s = s_axis_tvalid & src_enable;

    // Idle arbitration resumes after rr_ptr; last-beat re-arbitration resumes after the current grant.
    assign pick_ptr_s = (state_q == ARB_LOCKED) ? grant_q : rr_ptr_q;

    axis_rr_pick #(
        .G_NUM_SRC (G_NUM_SRC)
    ) u_pick (
        .req    (req_s),
        .ptr    (pick_ptr_s),
        .winner (pick_winner_s),
        .found  (pick_found_s)
    );

    // Zero-latency datapath mux and ready steering for the granted source.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == ARB_LOCKED) begin
            axis_streaming_data_tx_tdata  = s_axis_tdata[32'(grant_q)*G_AXIS_DATA_WIDTH +: G_AXIS_DATA_WIDTH];
            axis_streaming_data_tx_tkeep  = s_axis_tkeep[32'(grant_q)*KEEP_W +: KEEP_W];
            axis_streaming_data_tx_tvalid = s_axis_tvalid[grant_q];
            axis_streaming_data_tx_tuser  = s_axis_tuser[grant_q];
            axis_streaming_data_tx_tlast  = s_axis_tlast[grant_q];
            s_axis_tready[grant_q]        = axis_streaming_data_tx_tready;
            last_beat_s = s_axis_tvalid[grant_q] & s_axis_tlast[grant_q] & axis_streaming_data_tx_tready;
        end else begin
            axis_streaming_data_tx_tdata  = '0;
            axis_streaming_data_tx_tkeep  = '0;
            axis_streaming_data_tx_tvalid = 1'b0;
            axis_streaming_data_tx_tuser  = 1'b0;
            axis_streaming_data_tx_tlast  = 1'b0;
            last_beat_s                   = 1'b0;
        end
    end

    // Next-state logic: grant is held until the tlast handshake, then handed over in the same cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    state_d  = ARB_LOCKED;
                    grant_d  = pick_winner_s;
                    rr_ptr_d = pick_winner_s;
                end else begin
                    state_d  = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (last_beat_s) begin
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    if (pick_found_s) begin
                        state_d  = ARB_LOCKED;
                        grant_d  = pick_winner_s;
                        rr_ptr_d = pick_winner_s;
                    end else begin
                        state_d  = ARB_IDLE;
                    end
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d == ARB_LOCKED);
    end

    // Arbiter state and registered status; reset dominates a coincident last beat.
    always_ff @(posedge axis_streaming_data_clk) begin
        if (axis_streaming_arst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= IDX_W'(G_NUM_SRC - 32'd1);
            pkt_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign arb_grant_idx = grant_q;
    assign arb_busy      = busy_q;
    assign arb_pkt_cnt   = pkt_cnt_q;

endmodule
